// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and requester IDs.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; req[0] is the CPU, req[1] the DMA.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       sel
);

    always_comb begin
        valid = |req;
        sel   = REQ_CPU;
        // On a tie the requester that did not win last time is chosen.
        if (req == 2'b11) begin
            sel = ~last;
        end else if (req[1]) begin
            sel = REQ_DMA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between the CPU and the DMA/loader,
// running each granted access for MEM_LAT cycles and pulsing the owner's ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    arb_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic pick_valid;
    logic pick_sel;

    rr_pick2 u_pick (
        .req   ({dma_req, cpu_req}),
        .last  (last_q),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= REQ_DMA;
            owner_q <= REQ_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        cpu_ack   = 1'b0;
        dma_ack   = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_sel;
                    last_d  = pick_sel;
                    cnt_d   = LAT_M1;
                    state_d = ACCESS;
                    if (pick_sel == REQ_DMA) begin
                        we_d    = dma_we;
                        addr_d  = dma_addr;
                        wdata_d = dma_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end
            end
            ACCESS: begin
                busy      = 1'b1;
                mem_read  = ~we_q;
                mem_write = we_q;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                cpu_ack = (owner_q == REQ_CPU);
                dma_ack = (owner_q == REQ_DMA);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance and a MEM_LAT=1 instance,
// each attached to a small behavioural RAM.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- MEM_LAT = 2 instance ----------------
    logic       a_cpu_req = 0, a_cpu_we = 0, a_dma_req = 0, a_dma_we = 0;
    logic [4:0] a_cpu_addr = 0, a_dma_addr = 0;
    logic [7:0] a_cpu_wdata = 0, a_dma_wdata = 0;
    logic       a_cpu_ack, a_dma_ack, a_mem_read, a_mem_write, a_busy, a_owner;
    logic [4:0] a_mem_addr;
    logic [7:0] a_mem_wdata, a_mem_rdata, a_rdata;

    mem_port_arbiter #(.ADDR_W(5), .DATA_W(8), .MEM_LAT(2)) dut_a (
        .clk(clk), .rst(rst),
        .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr),
        .cpu_wdata(a_cpu_wdata), .cpu_ack(a_cpu_ack),
        .dma_req(a_dma_req), .dma_we(a_dma_we), .dma_addr(a_dma_addr),
        .dma_wdata(a_dma_wdata), .dma_ack(a_dma_ack),
        .rdata(a_rdata), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .busy(a_busy), .owner(a_owner)
    );

    // ---------------- MEM_LAT = 1 instance ----------------
    logic       b_cpu_req = 0, b_cpu_we = 0, b_dma_req = 0, b_dma_we = 0;
    logic [4:0] b_cpu_addr = 0, b_dma_addr = 0;
    logic [7:0] b_cpu_wdata = 0, b_dma_wdata = 0;
    logic       b_cpu_ack, b_dma_ack, b_mem_read, b_mem_write, b_busy, b_owner;
    logic [4:0] b_mem_addr;
    logic [7:0] b_mem_wdata, b_mem_rdata, b_rdata;

    mem_port_arbiter #(.ADDR_W(5), .DATA_W(8), .MEM_LAT(1)) dut_b (
        .clk(clk), .rst(rst),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr),
        .cpu_wdata(b_cpu_wdata), .cpu_ack(b_cpu_ack),
        .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr),
        .dma_wdata(b_dma_wdata), .dma_ack(b_dma_ack),
        .rdata(b_rdata), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .busy(b_busy), .owner(b_owner)
    );

    // ---------------- behavioural RAMs ----------------
    function automatic logic [7:0] init_byte(input int unsigned i);
        case (i)
            2:       init_byte = 8'h77;
            3:       init_byte = 8'hA5;
            4:       init_byte = 8'h11;
            6:       init_byte = 8'h42;
            7:       init_byte = 8'h88;
            8:       init_byte = 8'h22;
            default: init_byte = 8'hE0 | 8'(i);
        endcase
    endfunction

    logic [7:0] mem_a [32];
    logic [7:0] mem_b [32];
    logic       mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int unsigned i = 0; i < 32; i++) begin
                mem_a[i] <= init_byte(i);
                mem_b[i] <= init_byte(i);
            end
            mem_loaded <= 1'b1;
        end else begin
            if (a_mem_write) mem_a[a_mem_addr] <= a_mem_wdata;
            if (b_mem_write) mem_b[b_mem_addr] <= b_mem_wdata;
        end
    end

    assign a_mem_rdata = mem_a[a_mem_addr];
    assign b_mem_rdata = mem_b[b_mem_addr];

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on instance A starting from IDLE. Returns the number of
    // edges from request to ack, strobe cycles seen, strobe cycles with wrong
    // address/data/direction, and cycles where the non-owner ack was seen.
    task automatic txn(input logic who, input logic we, input logic [4:0] addr,
                       input logic [7:0] wd, input int chg_at, input logic [4:0] addr2,
                       output int lat, output int strb, output int bad, output int oth);
        lat = -1; strb = 0; bad = 0; oth = 0;
        if (who) begin
            a_dma_we = we; a_dma_addr = addr; a_dma_wdata = wd; a_dma_req = 1'b1;
        end else begin
            a_cpu_we = we; a_cpu_addr = addr; a_cpu_wdata = wd; a_cpu_req = 1'b1;
        end
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            tick();
            if (k == chg_at) begin
                if (who) a_dma_addr = addr2; else a_cpu_addr = addr2;
            end
            if (a_mem_read || a_mem_write) begin
                strb++;
                if (a_mem_addr !== addr || a_mem_write !== we || (we && a_mem_wdata !== wd))
                    bad++;
            end
            if (who ? a_cpu_ack : a_dma_ack) oth++;
            if (who ? a_dma_ack : a_cpu_ack) begin
                lat = k;
                if (who) a_dma_req = 1'b0; else a_cpu_req = 1'b0;
            end
        end
        a_cpu_req = 1'b0;
        a_dma_req = 1'b0;
        tick();
    endtask

    typedef struct {
        logic       who;
        logic       we;
        logic [4:0] addr;
        logic [7:0] wd;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    int lat, strb, bad, oth;
    int ev_n;
    int ev_cyc [8];
    logic ev_who [8];
    logic [7:0] ev_dat [8];
    int both_ack;
    int b_acks [4];
    int b_n;
    int rst_ack;

    initial begin
        vecs[0] = '{who: 1'b0, we: 1'b0, addr: 5'h03, wd: 8'h00, exp_rdata: 8'hA5};
        vecs[1] = '{who: 1'b1, we: 1'b1, addr: 5'h1F, wd: 8'h3C, exp_rdata: 8'hA5};
        vecs[2] = '{who: 1'b0, we: 1'b0, addr: 5'h1F, wd: 8'h00, exp_rdata: 8'h3C};
        vecs[3] = '{who: 1'b1, we: 1'b0, addr: 5'h03, wd: 8'h00, exp_rdata: 8'hA5};
        vecs[4] = '{who: 1'b0, we: 1'b1, addr: 5'h00, wd: 8'h5A, exp_rdata: 8'hA5};
        vecs[5] = '{who: 1'b1, we: 1'b0, addr: 5'h00, wd: 8'h00, exp_rdata: 8'h5A};

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy",  a_busy, 0);
        chk("rst_strb",  {a_mem_read, a_mem_write}, 0);
        chk("rst_acks",  {a_cpu_ack, a_dma_ack}, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_owner", a_owner, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            txn(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wd, 0, 5'h00,
                lat, strb, bad, oth);
            chk($sformatf("v%0d_lat", i), lat, 3);
            chk($sformatf("v%0d_strb", i), strb, 2);
            chk($sformatf("v%0d_addr", i), bad, 0);
            chk($sformatf("v%0d_other_ack", i), oth, 0);
            chk($sformatf("v%0d_rdata", i), a_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_owner", i), a_owner, vecs[i].who);
            chk($sformatf("v%0d_idle", i), a_busy, 0);
        end

        // Address change after grant must not disturb the in-flight access.
        txn(1'b0, 1'b0, 5'h02, 8'h00, 2, 5'h07, lat, strb, bad, oth);
        chk("chg_lat", lat, 3);
        chk("chg_addr_stable", bad, 0);
        chk("chg_rdata", a_rdata, 8'h77);

        // Reset in the middle of a DMA write.
        a_dma_we = 1'b1; a_dma_addr = 5'h1F; a_dma_wdata = 8'h99; a_dma_req = 1'b1;
        tick();
        tick();
        chk("mid_write_on", a_mem_write, 1);
        chk("mid_owner_dma", a_owner, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_strb", {a_mem_read, a_mem_write}, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_owner", a_owner, 0);
        a_dma_req = 1'b0;
        rst_ack = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (a_dma_ack || a_cpu_ack) rst_ack++;
        end
        chk("mid_rst_no_ack", rst_ack, 0);
        rst = 1'b0;
        tick();

        // Tie after reset: CPU first, then alternation every 4 cycles.
        a_cpu_we = 1'b0; a_cpu_addr = 5'h04; a_cpu_req = 1'b1;
        a_dma_we = 1'b0; a_dma_addr = 5'h08; a_dma_req = 1'b1;
        ev_n = 0; both_ack = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (a_cpu_ack && a_dma_ack) both_ack++;
            if ((a_cpu_ack || a_dma_ack) && ev_n < 8) begin
                ev_cyc[ev_n] = k;
                ev_who[ev_n] = a_dma_ack;
                ev_dat[ev_n] = a_rdata;
                ev_n++;
            end
        end
        a_cpu_req = 1'b0;
        a_dma_req = 1'b0;
        tick();
        chk("tie_events", ev_n, 4);
        chk("tie_both_ack", both_ack, 0);
        for (int i = 0; i < 4 && i < ev_n; i++) begin
            chk($sformatf("tie%0d_cyc", i), ev_cyc[i], 3 + 4 * i);
            chk($sformatf("tie%0d_who", i), ev_who[i], i % 2);
            chk($sformatf("tie%0d_data", i), ev_dat[i], (i % 2) ? 8'h22 : 8'h11);
        end

        // MEM_LAT = 1 instance: single read, then back-to-back reads.
        b_cpu_we = 1'b0; b_cpu_addr = 5'h06; b_cpu_req = 1'b1;
        lat = -1; strb = 0;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            tick();
            if (b_mem_read) strb++;
            if (b_cpu_ack) begin
                lat = k;
                b_cpu_req = 1'b0;
            end
        end
        b_cpu_req = 1'b0;
        tick();
        chk("l1_lat", lat, 2);
        chk("l1_strb", strb, 1);
        chk("l1_rdata", b_rdata, 8'h42);

        b_cpu_req = 1'b1;
        b_n = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (b_cpu_ack && b_n < 4) begin
                b_acks[b_n] = k;
                b_n++;
            end
        end
        b_cpu_req = 1'b0;
        tick();
        chk("l1_b2b_count", b_n, 3);
        for (int i = 0; i < 3 && i < b_n; i++)
            chk($sformatf("l1_b2b%0d_cyc", i), b_acks[i], 2 + 3 * i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
